// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_pkg
//  Description : Shared constants, FSM state type and branch-metric helper
//                for the Viterbi add-compare-select scheduler.
//                K_DEF / M_DEF / MW_DEF  : default code and metric geometry
//                S                       : number of trellis states (2^M)
//                INIT_METRIC / MW_MAX    : unreachable-state seed, saturation
//                fsm_state_e             : IDLE / RUN / DONE
//                bm2()                   : Hamming distance of two 2-bit symbols
//  Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    localparam int K_DEF       = 5;
    localparam int M_DEF       = K_DEF - 1;
    localparam int S           = 1 << M_DEF;
    localparam int MW_DEF      = 8;
    localparam int INIT_METRIC = 1 << (MW_DEF - 1);
    localparam int MW_MAX      = (1 << MW_DEF) - 1;
    localparam int G0_OCT_DEF  = 'o23;
    localparam int G1_OCT_DEF  = 'o35;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Hamming distance between the expected and received bit pair (0..2).
    function automatic logic [1:0] bm2(input logic [1:0] e, input logic [1:0] sym);
        logic [1:0] d;
        d = e ^ sym;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/expected_bits.sv
`default_nettype none
// ============================================================================
//  Module      : expected_bits
//  Description : Encoder output lookup for one trellis branch.
//                pred_i : predecessor state (bit 0 = most recent input)
//                b_i    : input bit driving the branch (newest register bit)
//                e_o    : {G1 parity, G0 parity} of the register {pred_i, b_i}
//  Revision    : 1.0 - initial release
// ============================================================================
module expected_bits #(
    parameter int M      = 4,
    parameter int G0_OCT = 'o23,
    parameter int G1_OCT = 'o35
) (
    input  logic [M-1:0] pred_i,
    input  logic         b_i,
    output logic [1:0]   e_o
);

    // Generator tap i multiplies register bit i; bit 0 holds the newest input.
    localparam logic [M:0] C_G0 = (M+1)'(G0_OCT);
    localparam logic [M:0] C_G1 = (M+1)'(G1_OCT);

    logic [M:0] w_reg;

    assign w_reg = {pred_i, b_i};
    assign e_o   = {^(w_reg & C_G1), ^(w_reg & C_G0)};

endmodule
`default_nettype wire

// File: rtl/viterbi_acs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_acs_scheduler
//  Description : Runs one trellis step per accepted hard-decision symbol.
//                Walks all 2^M next states one per cycle, performs
//                add-compare-select against ping-pong path-metric banks and
//                streams one survivor bit per state.
//  Ports       : clk, rst_n           clock, async active-low reset
//                init_i               re-seed metrics (only honoured in IDLE)
//                sym_valid_i/ready_o  symbol handshake
//                sym_i                received {y1,y0}
//                surv_valid_o         one pulse per state, contiguous
//                surv_state_o         next-state index of the survivor
//                surv_bit_o           chosen predecessor MSB
//                step_done_o          one-cycle pulse closing a step
//                best_state_o         lowest-index argmin of the new metrics
//                best_metric_o        that minimum, before normalisation
//  Revision    : 1.0 - initial release
// ============================================================================
module viterbi_acs_scheduler
    import viterbi_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int M      = K - 1,
    parameter int G0_OCT = G0_OCT_DEF,
    parameter int G1_OCT = G1_OCT_DEF,
    parameter int MW     = MW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_i,
    input  logic          sym_valid_i,
    output logic          sym_ready_o,
    input  logic [1:0]    sym_i,
    output logic          surv_valid_o,
    output logic [M-1:0]  surv_state_o,
    output logic          surv_bit_o,
    output logic          step_done_o,
    output logic [M-1:0]  best_state_o,
    output logic [MW-1:0] best_metric_o
);

    localparam int          NS     = (M == M_DEF) ? S : (1 << M);
    localparam logic [MW-1:0] C_INIT = (MW == MW_DEF) ? MW'(INIT_METRIC) : MW'(1 << (MW - 1));
    localparam logic [MW-1:0] C_MAX  = (MW == MW_DEF) ? MW'(MW_MAX) : {MW{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_state_e    state_q, state_d;
    logic [M-1:0]  cnt_q, cnt_d;
    logic [1:0]    sym_q;
    logic          bank_q;
    logic [MW-1:0] prev_min_q;
    logic [MW-1:0] run_min_q;
    logic [M-1:0]  run_state_q;
    logic [MW-1:0] best_metric_q;
    logic [M-1:0]  best_state_q;
    logic          surv_valid_q;
    logic [M-1:0]  surv_state_q;
    logic          surv_bit_q;
    logic [MW-1:0] pm_q [2][NS];

    // ------------------------------------------------------------------
    // Branch evaluation for next state s = cnt_q
    // ------------------------------------------------------------------
    logic          w_b;
    logic [M-1:0]  w_pred0, w_pred1;
    logic [1:0]    w_e0, w_e1;
    logic [1:0]    w_bm0, w_bm1;
    logic [MW-1:0] w_rd0, w_rd1;
    logic [MW:0]   w_sum0, w_sum1;
    logic [MW-1:0] w_cand0, w_cand1, w_cand;
    logic          w_x;
    logic          w_take;
    logic [MW-1:0] w_min_metric;
    logic [M-1:0]  w_min_state;
    logic          w_last;
    logic          w_accept;
    logic          w_new_bank;

    // Predecessors differ only in the oldest bit, which shifts out.
    assign w_b     = cnt_q[0];
    assign w_pred0 = {1'b0, cnt_q[M-1:1]};
    assign w_pred1 = {1'b1, cnt_q[M-1:1]};

    expected_bits #(
        .M      (M),
        .G0_OCT (G0_OCT),
        .G1_OCT (G1_OCT)
    ) u_eb_pred0 (
        .pred_i (w_pred0),
        .b_i    (w_b),
        .e_o    (w_e0)
    );

    expected_bits #(
        .M      (M),
        .G0_OCT (G0_OCT),
        .G1_OCT (G1_OCT)
    ) u_eb_pred1 (
        .pred_i (w_pred1),
        .b_i    (w_b),
        .e_o    (w_e1)
    );

    assign w_bm0 = bm2(w_e0, sym_q);
    assign w_bm1 = bm2(w_e1, sym_q);

    // prev_min is the minimum of the old bank, so these never wrap.
    assign w_rd0 = pm_q[bank_q][w_pred0] - prev_min_q;
    assign w_rd1 = pm_q[bank_q][w_pred1] - prev_min_q;

    assign w_sum0 = {1'b0, w_rd0} + {{(MW-1){1'b0}}, w_bm0};
    assign w_sum1 = {1'b0, w_rd1} + {{(MW-1){1'b0}}, w_bm1};

    assign w_cand0 = w_sum0[MW] ? C_MAX : w_sum0[MW-1:0];
    assign w_cand1 = w_sum1[MW] ? C_MAX : w_sum1[MW-1:0];

    // Ties resolve toward predecessor x=0.
    assign w_x    = (w_cand1 < w_cand0);
    assign w_cand = w_x ? w_cand1 : w_cand0;

    // Running minimum restarts at state 0; strict compare keeps lowest index.
    assign w_take       = (cnt_q == '0) || (w_cand < run_min_q);
    assign w_min_metric = w_take ? w_cand : run_min_q;
    assign w_min_state  = w_take ? cnt_q  : run_state_q;

    assign w_last     = &cnt_q;
    assign w_accept   = (state_q == IDLE) && sym_valid_i && !init_i;
    assign w_new_bank = ~bank_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sym_ready_o = 1'b0;
        step_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                sym_ready_o = !init_i;
                if (w_accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                step_done_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sym_q         <= '0;
            bank_q        <= 1'b0;
            prev_min_q    <= '0;
            run_min_q     <= '0;
            run_state_q   <= '0;
            best_metric_q <= '0;
            best_state_q  <= '0;
            surv_valid_q  <= 1'b0;
            surv_state_q  <= '0;
            surv_bit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            surv_valid_q <= (state_q == RUN);
            if (w_accept) begin
                sym_q <= sym_i;
            end
            if ((state_q == IDLE) && init_i) begin
                bank_q     <= 1'b0;
                prev_min_q <= '0;
            end
            if (state_q == RUN) begin
                surv_state_q <= cnt_q;
                surv_bit_q   <= w_x;
                run_min_q    <= w_min_metric;
                run_state_q  <= w_min_state;
                if (w_last) begin
                    best_metric_q <= w_min_metric;
                    best_state_q  <= w_min_state;
                end
            end
            if (state_q == DONE) begin
                bank_q     <= w_new_bank;
                prev_min_q <= run_min_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Path-metric banks: old bank read, opposite bank written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NS; i++) begin
                    pm_q[b][i] <= ((b == 0) && (i == 0)) ? '0 : C_INIT;
                end
            end
        end else if ((state_q == IDLE) && init_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NS; i++) begin
                    pm_q[b][i] <= ((b == 0) && (i == 0)) ? '0 : C_INIT;
                end
            end
        end else if (state_q == RUN) begin
            pm_q[w_new_bank][cnt_q] <= w_cand;
        end
    end

    assign surv_valid_o  = surv_valid_q;
    assign surv_state_o  = surv_state_q;
    assign surv_bit_o    = surv_bit_q;
    assign best_state_o  = best_state_q;
    assign best_metric_o = best_metric_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_acs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_viterbi_acs_scheduler
//  Description : Self-checking bench for viterbi_acs_scheduler (K=5, 23/35,
//                MW=8). Reference model is a whole-step trellis update built
//                from a forward convolutional encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_acs_scheduler;

    localparam int NS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym;
    logic       surv_valid;
    logic [3:0] surv_state;
    logic       surv_bit;
    logic       step_done;
    logic [3:0] best_state;
    logic [7:0] best_metric;

    viterbi_acs_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_i        (init),
        .sym_valid_i   (sym_valid),
        .sym_ready_o   (sym_ready),
        .sym_i         (sym),
        .surv_valid_o  (surv_valid),
        .surv_state_o  (surv_state),
        .surv_bit_o    (surv_bit),
        .step_done_o   (step_done),
        .best_state_o  (best_state),
        .best_metric_o (best_metric)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pm [NS];
    int m_prev;
    int e_bits [NS];
    int e_best_s, e_best_m;

    // Encoder output {y1,y0} when input u enters a register holding state st.
    function automatic int enc(input int st, input int u);
        int r;
        r = ((st << 1) | u) & 31;
        return (($countones(r & 'o35) & 1) << 1) | ($countones(r & 'o23) & 1);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) m_pm[i] = (i == 0) ? 0 : 128;
        m_prev = 0;
    endfunction

    function automatic void model_step(input int sy);
        int cand [2][NS];
        int nw [NS];
        for (int p = 0; p < NS; p++) begin
            for (int u = 0; u < 2; u++) begin
                int ns, c;
                ns = ((p << 1) | u) & (NS - 1);
                c  = m_pm[p] - m_prev + $countones(enc(p, u) ^ sy);
                if (c > 255) c = 255;
                cand[p >> 3][ns] = c;
            end
        end
        for (int s = 0; s < NS; s++) begin
            e_bits[s] = (cand[1][s] < cand[0][s]) ? 1 : 0;
            nw[s]     = cand[e_bits[s]][s];
        end
        e_best_s = 0;
        e_best_m = nw[0];
        for (int s = 1; s < NS; s++) begin
            if (nw[s] < e_best_m) begin
                e_best_m = nw[s];
                e_best_s = s;
            end
        end
        for (int s = 0; s < NS; s++) m_pm[s] = nw[s];
        m_prev = e_best_m;
    endfunction

    // ---------------- captured step results ----------------
    int g_bits [NS];
    int g_best_s, g_best_m, g_done_cyc, g_pulses;

    task automatic do_reset();
        rst_n = 1'b0; init = 1'b0; sym_valid = 1'b0; sym = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sym_ready", int'(sym_ready), 1);
        chk("rst_surv_valid", int'(surv_valid), 0);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_best_state", int'(best_state), 0);
        chk("rst_best_metric", int'(best_metric), 0);
        model_reset();
    endtask

    // One full step: handshake, collect survivors, check against the model.
    task automatic run_step(input int sy, input int init_cyc, input bit use_model);
        int  t;
        bit  done;
        t = 0;
        while (sym_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("sym_ready_wait", int'(sym_ready === 1'b1), 1);
        sym = 2'(sy); sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        sym = 2'($urandom);
        g_pulses = 0; g_done_cyc = -1; g_best_s = -1; g_best_m = -1;
        for (int s = 0; s < NS; s++) g_bits[s] = -1;
        done = 1'b0;
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            init = (cyc == init_cyc);
            chk("sym_ready_busy", int'(sym_ready), 0);
            if (surv_valid) begin
                chk("surv_state_order", int'(surv_state), g_pulses);
                chk("surv_cycle", cyc, g_pulses + 2);
                g_bits[surv_state] = int'(surv_bit);
                g_pulses++;
            end
            if (step_done) begin
                g_done_cyc = cyc;
                g_best_s   = int'(best_state);
                g_best_m   = int'(best_metric);
                done       = 1'b1;
            end
        end
        init = 1'b0;
        chk("step_done_cycle", g_done_cyc, 17);
        chk("surv_pulses", g_pulses, 16);
        @(negedge clk);
        chk("best_metric_hold", int'(best_metric), g_best_m);
        if (use_model) begin
            model_step(sy);
            for (int s = 0; s < NS; s++) chk($sformatf("surv_bit_s%0d", s), g_bits[s], e_bits[s]);
            chk("best_state_model", g_best_s, e_best_s);
            chk("best_metric_model", g_best_m, e_best_m);
        end
    endtask

    typedef struct {
        logic [1:0] sym;
        int         best_s;
        int         best_m;
        int         bit_s0;
        int         bit_s1;
        int         bit_s8;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, u, y, na, nd, last_acc;
        logic [19:0] bits;

        // First step after reset from state 0 only.
        tbl[0] = '{2'b00, 0, 0, 0, 0, 0};
        tbl[1] = '{2'b11, 1, 0, 0, 0, 0};
        tbl[2] = '{2'b01, 0, 1, 0, 0, 1};
        tbl[3] = '{2'b10, 0, 1, 0, 0, 0};

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_step(int'(tbl[i].sym), 0, 1'b1);
            chk($sformatf("tbl%0d_best_state", i), g_best_s, tbl[i].best_s);
            chk($sformatf("tbl%0d_best_metric", i), g_best_m, tbl[i].best_m);
            chk($sformatf("tbl%0d_bit_s0", i), g_bits[0], tbl[i].bit_s0);
            chk($sformatf("tbl%0d_bit_s1", i), g_bits[1], tbl[i].bit_s1);
            chk($sformatf("tbl%0d_bit_s8", i), g_bits[8], tbl[i].bit_s8);
        end

        // Error-free encoded stream.
        bits = 20'b1011001110_0100110101;
        do_reset();
        st = 0;
        for (int i = 0; i < 20; i++) begin
            u  = int'(bits[19 - i]);
            y  = enc(st, u);
            st = ((st << 1) | u) & (NS - 1);
            run_step(y, 0, 1'b1);
            chk("clean_best_metric", g_best_m, 0);
            chk("clean_best_state", g_best_s, st);
        end

        // Same stream with one bit error on symbol 5.
        do_reset();
        st = 0;
        for (int i = 0; i < 20; i++) begin
            u  = int'(bits[19 - i]);
            y  = enc(st, u);
            st = ((st << 1) | u) & (NS - 1);
            if (i == 5) y = y ^ 1;
            run_step(y, 0, 1'b1);
            if (i < 5)  chk("err_pre_metric", g_best_m, 0);
            if (i == 5) chk("err_step5_metric", g_best_m, 1);
            if (i >= 6) begin
                chk("err_post_state", g_best_s, st);
                chk("err_post_metric", g_best_m, 0);
            end
        end

        // Random symbols; init pulses mid-step must be ignored.
        for (int i = 0; i < 1000; i++) begin
            run_step(int'($urandom_range(3, 0)), (i % 50 == 7) ? 5 : 0, 1'b1);
            chk("metric_below_sat", int'(g_best_m < 255), 1);
        end

        // init in IDLE re-seeds metrics and blocks the handshake.
        init = 1'b1; sym_valid = 1'b1;
        #1;
        chk("init_blocks_ready", int'(sym_ready), 0);
        @(negedge clk);
        init = 1'b0; sym_valid = 1'b0;
        model_reset();
        run_step(0, 0, 1'b1);
        chk("reinit_best_state", g_best_s, 0);
        chk("reinit_best_metric", g_best_m, 0);

        // Continuous sym_valid: one accept every 18 cycles.
        do_reset();
        sym_valid = 1'b1;
        na = 0; nd = 0; last_acc = -1;
        for (int c = 0; c < 74; c++) begin
            sym = 2'($urandom);
            if (step_done) nd++;
            if (sym_ready) begin
                if (last_acc >= 0) chk("accept_spacing", c - last_acc, 18);
                last_acc = c;
                na++;
            end
            @(negedge clk);
        end
        sym_valid = 1'b0;
        chk("accept_count", na, 5);
        chk("done_count", nd, 4);

        // Async reset at cnt=7 discards the step.
        do_reset();
        sym = 2'b11; sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_step_done", int'(step_done), 0);
        chk("midrun_rst_ready", int'(sym_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0; na = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (step_done) nd++;
            if (surv_valid) na++;
        end
        chk("midrun_no_step_done", nd, 0);
        chk("midrun_no_surv", na, 0);
        init = 1'b1;
        #1;
        chk("midrun_init_ready", int'(sym_ready), 0);
        @(negedge clk);
        init = 1'b0;
        model_reset();
        run_step(int'(tbl[0].sym), 0, 1'b1);
        chk("post_rst_best_state", g_best_s, tbl[0].best_s);
        chk("post_rst_best_metric", g_best_m, tbl[0].best_m);
        chk("post_rst_bit_s8", g_bits[8], tbl[0].bit_s8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
